// File: rtl/ext_bus_port.sv
// ext_bus_port: DSP external-bus slave port.
//   Write path: programmable settle delay, one-cycle wr_stb per write cycle.
//   Read path:  registered, priority-muxed read of NCH channels onto db.
//   Collision:  sticky flag when read and write strobes overlap.
// Optional feature macro: BUS_ACCESS_CNT_EN adds access_cnt = {miss, writes}.
// Ports:
//   xclk, reset          clock, async active-high reset
//   db                   bidirectional data bus (driven only while reading)
//   re, we, cs           active-low read/write enables and chip select
//   ab                   address bus
//   addr                 registered ab - AB_OFFSET
//   wr_stb, wr_data      write strobe and captured write data
//   rd_qual              combinational !re & !cs for sub-module decode
//   rd_avail, rd_data    per-channel read valid and data (channel k at [k*DW +: DW])
//   collision            sticky bus-collision flag
//   access_cnt           {read misses, completed writes} (BUS_ACCESS_CNT_EN only)
module ext_bus_port #(
    parameter int unsigned      DW           = 16,
    parameter int unsigned      AW           = 8,
    parameter int unsigned      NCH          = 8,
    parameter int unsigned      WE_DLY       = 2,
    parameter logic [AW-1:0]    AB_OFFSET    = '0,
    parameter logic [DW-1:0]    DEFAULT_DATA = DW'(16'h3333)
) (
    input  logic                xclk,
    input  logic                reset,
    inout  wire  [DW-1:0]       db,
    input  logic                re,
    input  logic                we,
    input  logic                cs,
    input  logic [AW-1:0]       ab,
    output logic [AW-1:0]       addr,
    output logic                wr_stb,
    output logic [DW-1:0]       wr_data,
    output logic                rd_qual,
    input  logic [NCH-1:0]      rd_avail,
    input  logic [NCH*DW-1:0]   rd_data,
    output logic                collision
`ifdef BUS_ACCESS_CNT_EN
    ,
    output logic [31:0]         access_cnt
`endif
);

    localparam int unsigned CW = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WSETTLE = 2'd1,
        WHOLD   = 2'd2,
        READ    = 2'd3
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_n;
    logic            oe;
    logic            oe_n;
    logic [DW-1:0]   dout;
    logic            cap_d;
    logic            capture_c;
    logic            guard_c;
    logic            wlow_c;
    logic [DW-1:0]   sel_data_c;

    assign wlow_c  = !we && !cs;
    assign rd_qual = !re && !cs;

    // Output enable register gates the bus; reset clears it asynchronously.
    assign db = oe ? dout : {DW{1'bz}};

    // State register.
    always_ff @(posedge xclk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next-state logic; a write request always wins over a read.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        oe_n      = 1'b0;
        capture_c = 1'b0;
        guard_c   = 1'b0;
        case (state)
            IDLE: begin
                if (wlow_c) begin
                    state_n = WSETTLE;
                    cnt_n   = CW'(1);
                end else if (rd_qual) begin
                    state_n = READ;
                end
            end
            WSETTLE: begin
                if (!wlow_c) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt == CW'(WE_DLY)) begin
                    state_n   = WHOLD;
                    cnt_n     = '0;
                    capture_c = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            WHOLD: begin
                if (!wlow_c) begin
                    state_n = IDLE;
                end
            end
            READ: begin
                // A write arriving mid-read releases the bus and restarts as a write.
                if (wlow_c) begin
                    state_n = WSETTLE;
                    cnt_n   = CW'(1);
                    guard_c = 1'b1;
                end else if (!rd_qual) begin
                    state_n = IDLE;
                end else begin
                    oe_n = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Lowest-index available channel wins.
    always_comb begin
        sel_data_c = DEFAULT_DATA;
        for (int i = int'(NCH) - 1; i >= 0; i--) begin
            if (rd_avail[i]) begin
                sel_data_c = rd_data[i*DW +: DW];
            end
        end
    end

    // Datapath and flag registers; wr_stb trails the capture edge by one cycle.
    always_ff @(posedge xclk or posedge reset) begin
        if (reset) begin
            oe        <= 1'b0;
            dout      <= '0;
            addr      <= '0;
            wr_data   <= '0;
            cap_d     <= 1'b0;
            wr_stb    <= 1'b0;
            collision <= 1'b0;
        end else begin
            oe     <= oe_n;
            addr   <= ab - AB_OFFSET;
            cap_d  <= capture_c;
            wr_stb <= cap_d;
            if (state == READ) begin
                dout <= sel_data_c;
            end
            if (capture_c) begin
                wr_data <= db;
            end
            if ((!re && !we && !cs) || guard_c) begin
                collision <= 1'b1;
            end
        end
    end

`ifdef BUS_ACCESS_CNT_EN
    logic [15:0] wr_cnt;
    logic [15:0] miss_cnt;
    logic        miss_c;

    // A miss is counted once per read cycle, on the edge that first drives the bus.
    assign miss_c = oe_n && !oe && (rd_avail == '0);

    always_ff @(posedge xclk or posedge reset) begin
        if (reset) begin
            wr_cnt   <= '0;
            miss_cnt <= '0;
        end else begin
            if (wr_stb && (wr_cnt != 16'hFFFF)) begin
                wr_cnt <= wr_cnt + 16'd1;
            end
            if (miss_c && (miss_cnt != 16'hFFFF)) begin
                miss_cnt <= miss_cnt + 16'd1;
            end
        end
    end

    assign access_cnt = {miss_cnt, wr_cnt};
`endif

endmodule

// File: tb/tb_ext_bus_port.sv
// Testbench for ext_bus_port: directed and randomized bus cycles checked against
// a transaction-level model of the write/read/collision rules.
module tb_ext_bus_port;

    localparam int unsigned DW     = 16;
    localparam int unsigned AW     = 8;
    localparam int unsigned NCH    = 8;
    localparam int unsigned WE_DLY = 2;
    localparam logic [7:0]  OFF    = 8'h10;
    localparam logic [15:0] RELEASED = 16'hFFFF;

    logic               xclk = 1'b0;
    logic               reset;
    wire  [DW-1:0]      db;
    logic [DW-1:0]      db_drv;
    logic               db_en;
    logic               re;
    logic               we;
    logic               cs;
    logic [AW-1:0]      ab;
    logic [AW-1:0]      addr;
    logic               wr_stb;
    logic [DW-1:0]      wr_data;
    logic               rd_qual;
    logic [NCH-1:0]     rd_avail;
    logic [NCH*DW-1:0]  rd_data;
    logic               collision;
`ifdef BUS_ACCESS_CNT_EN
    logic [31:0]        access_cnt;
`endif

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] exp_wdata;
    int          exp_writes;
    int          exp_miss;

    // Released bus reads back as all ones.
    assign db = db_en ? db_drv : {DW{1'bz}};
    pullup (db);

    always #5 xclk = ~xclk;

    ext_bus_port #(
        .DW(DW), .AW(AW), .NCH(NCH), .WE_DLY(WE_DLY),
        .AB_OFFSET(OFF), .DEFAULT_DATA(16'h3333)
    ) dut (
        .xclk(xclk), .reset(reset), .db(db), .re(re), .we(we), .cs(cs),
        .ab(ab), .addr(addr), .wr_stb(wr_stb), .wr_data(wr_data),
        .rd_qual(rd_qual), .rd_avail(rd_avail), .rd_data(rd_data),
        .collision(collision)
`ifdef BUS_ACCESS_CNT_EN
        , .access_cnt(access_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge xclk);
        #1;
    endtask

    function automatic logic [15:0] r16();
        logic [15:0] v;
        v = 16'($urandom);
        if (v == RELEASED) v = 16'hFFFE;
        return v;
    endfunction

    // Reference read value: first channel (from 0) with valid data, else default.
    function automatic logic [15:0] ref_mux(input logic [7:0] av, input logic [127:0] dat);
        for (int c = 0; c < 8; c++) begin
            if (av[c]) return dat[c*16 +: 16];
        end
        return 16'h3333;
    endfunction

    task automatic rand_rd();
        rd_avail = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
        for (int c = 0; c < 8; c++) rd_data[c*16 +: 16] = r16();
    endtask

    // Write cycle with we/cs low for len sampled edges.
    task automatic do_write(input int len, input logic [7:0] a, input logic [15:0] d);
        bit ok;
        ok = (len >= int'(WE_DLY) + 1);
        ab = a; db_drv = d; db_en = 1'b1; we = 1'b0; cs = 1'b0;
        for (int k = 1; k <= len + 4; k++) begin
            cyc();
            if (k == 1) chk("addr", 32'(addr), 32'(8'(a - OFF)));
            chk("wr_stb", 32'(wr_stb), 32'(ok && (k == int'(WE_DLY) + 2)));
            if (k == len) begin
                we = 1'b1; cs = 1'b1;
            end
        end
        db_en = 1'b0;
        if (ok) begin
            exp_wdata = d;
            exp_writes++;
        end
        chk("wr_data", 32'(wr_data), 32'(exp_wdata));
    endtask

    // Read cycle with re/cs low for len sampled edges.
    task automatic do_read(input int len, input bit rnd);
        logic [7:0]   av;
        logic [127:0] dat;
        ab = 8'($urandom);
        re = 1'b0; cs = 1'b0;
        #1;
        chk("rd_qual_on", 32'(rd_qual), 32'd1);
        for (int k = 1; k <= len + 2; k++) begin
            av = rd_avail; dat = rd_data;
            cyc();
            if (k >= 2 && k <= len) begin
                chk("rd_db", 32'(db), 32'(ref_mux(av, dat)));
                if (k == 2 && av == 8'h00) exp_miss++;
            end else begin
                chk("rd_release", 32'(db), 32'(RELEASED));
            end
            if (rnd) rand_rd();
            if (k == len) begin
                re = 1'b1; cs = 1'b1;
            end
        end
        #1;
        chk("rd_qual_off", 32'(rd_qual), 32'd0);
    endtask

    initial begin
        logic [15:0] d;
        logic [7:0]  av;
        logic [127:0] dat;
        reset = 1'b1; re = 1'b1; we = 1'b1; cs = 1'b1; ab = 8'h5A;
        db_en = 1'b0; db_drv = '0; rd_avail = '0; rd_data = '0;
        exp_wdata = '0; exp_writes = 0; exp_miss = 0;

        // Reset state
        cyc(); cyc();
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_wr_stb", 32'(wr_stb), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_collision", 32'(collision), 32'd0);
        chk("rst_db", 32'(db), 32'(RELEASED));
        chk("rst_rd_qual", 32'(rd_qual), 32'd0);
        reset = 1'b0;
        cyc();

        // Directed write, then short write that must be dropped
        do_write(6, 8'h35, 16'hA5C3);
        chk("addr_dir", 32'(addr), 32'h25);
        cyc();
        do_write(2, 8'h40, 16'h1111);
        cyc();

        // Read priority: ch2 beats ch5
        rd_avail = 8'b0010_0100;
        rd_data = '0;
        rd_data[2*16 +: 16] = 16'h1234;
        rd_data[5*16 +: 16] = 16'hBEEF;
        do_read(4, 1'b0);
        cyc();

        // Read miss
        rd_avail = 8'h00;
        do_read(3, 1'b0);
        cyc();
        chk("no_collision", 32'(collision), 32'd0);

        // Randomized mix of reads and writes
        for (int t = 0; t < 24; t++) begin
            if ($urandom_range(0, 1) == 0) begin
                do_write(int'($urandom_range(1, 6)), 8'($urandom), r16());
            end else begin
                rand_rd();
                do_read(int'($urandom_range(1, 5)), 1'b1);
            end
            cyc();
        end
        chk("no_collision_rand", 32'(collision), 32'd0);

        // Collision: write arrives during a read
        rd_avail = 8'h01; rd_data[15:0] = 16'h0F0F;
        re = 1'b0; cs = 1'b0;
        cyc(); cyc(); cyc();
        chk("col_db_driven", 32'(db), 32'h0F0F);
        we = 1'b0;
        cyc();
        chk("col_release", 32'(db), 32'(RELEASED));
        chk("col_flag", 32'(collision), 32'd1);
        d = r16();
        db_drv = d; db_en = 1'b1;
        for (int j = 1; j <= 5; j++) begin
            cyc();
            chk("col_wr_stb", 32'(wr_stb), 32'(j == int'(WE_DLY) + 1));
            if (j == 4) begin
                we = 1'b1; re = 1'b1; cs = 1'b1;
            end
        end
        db_en = 1'b0;
        exp_wdata = d; exp_writes++;
        chk("col_wr_data", 32'(wr_data), 32'(d));
        chk("col_sticky", 32'(collision), 32'd1);
        cyc();

        // Reset in the middle of write settling
        ab = 8'h77; db_drv = 16'hC0DE; db_en = 1'b1; we = 1'b0; cs = 1'b0;
        cyc(); cyc();
        reset = 1'b1;
        #1;
        chk("rstw_wr_stb", 32'(wr_stb), 32'd0);
        chk("rstw_wr_data", 32'(wr_data), 32'd0);
        chk("rstw_addr", 32'(addr), 32'd0);
        chk("rstw_collision", 32'(collision), 32'd0);
        exp_wdata = '0; exp_writes = 0; exp_miss = 0;
        cyc();
        we = 1'b1; cs = 1'b1; db_en = 1'b0; reset = 1'b0;
        for (int j = 0; j < 5; j++) begin
            cyc();
            chk("rstw_no_stb", 32'(wr_stb), 32'd0);
        end

        // Reset in the middle of a read: bus releases without a clock edge
        rd_avail = 8'h80; rd_data[127:112] = 16'h2468;
        re = 1'b0; cs = 1'b0;
        cyc(); cyc(); cyc();
        chk("rstr_db_driven", 32'(db), 32'h2468);
        reset = 1'b1;
        #1;
        chk("rstr_db_async", 32'(db), 32'(RELEASED));
        cyc();
        re = 1'b1; cs = 1'b1; reset = 1'b0;
        cyc();
        chk("rstr_db_idle", 32'(db), 32'(RELEASED));
        chk("rstr_wr_data", 32'(wr_data), 32'd0);

        // Post-reset traffic
        do_write(3, 8'h12, 16'h5AA5);
        cyc();
        rd_avail = 8'h00;
        do_read(2, 1'b0);
        cyc();
        av = 8'h10; dat = '0; dat[4*16 +: 16] = 16'h7777;
        rd_avail = av; rd_data = dat;
        do_read(3, 1'b0);
        cyc();

`ifdef BUS_ACCESS_CNT_EN
        chk("access_cnt", access_cnt, {16'(exp_miss), 16'(exp_writes)});
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
